tensor_wb_stage: RTL and testbench

- Downstream writeback stage of the tensor core.
- Accepts one completed result per instruction: warp id, destination register, thread mask, and one XLEN word per thread. Buffers results in a small in-order FIFO.
- Serialises each result into WB_LANES-wide beats toward the commit/register-file writeback port, using valid/ready.
- Exports a per-warp pending bitmap so the issue logic can stall dependent tensor instructions.

---
 rtl/tensor_pkg.sv | 21 ++
 rtl/tensor_wb_fifo.sv | 44 ++++
 rtl/tensor_wb_stage.sv | 87 ++++++++
 tb/tb_tensor_wb_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tensor_pkg.sv
// tensor_pkg: shared tensor-core writeback types, default geometry and width helpers.
package tensor_pkg;
  localparam int DEF_THREADS = 4;
  localparam int DEF_XLEN = 32;
  localparam int DEF_WARPS = 8;
  localparam int DEF_REGS = 32;
  localparam int DEF_WB_LANES = 4;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int WW = clog2_min1(DEF_WARPS);
  localparam int RW = $clog2(DEF_REGS);
  localparam int BW = clog2_min1(DEF_THREADS / DEF_WB_LANES);
  typedef struct packed {
    logic [WW-1:0] wid;
    logic [RW-1:0] rd;
    logic [DEF_THREADS-1:0] tmask;
    logic [DEF_THREADS*DEF_XLEN-1:0] data;
  } wb_entry_t;
  typedef logic [BW-1:0] wb_beat_t;
endpackage

// File: rtl/tensor_wb_fifo.sv
// tensor_wb_fifo: circular buffer of entries with push/pop and full/empty flags.
module tensor_wb_fifo
  import tensor_pkg::*;
#(
  parameter type T = wb_entry_t,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  // wrap explicitly so non-power-of-2 depths never index past the last slot
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop) rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/tensor_wb_stage.sv
// tensor_wb_stage: buffers tensor results and serialises them into writeback beats,
// tracking per-warp pending results for issue stalls.
module tensor_wb_stage
  import tensor_pkg::*;
#(
  parameter int NUM_THREADS = DEF_THREADS,
  parameter int XLEN = DEF_XLEN,
  parameter int NUM_WARPS = DEF_WARPS,
  parameter int NUM_REGS = DEF_REGS,
  parameter int DEPTH = 2,
  parameter int WB_LANES = DEF_WB_LANES,
  localparam int NUM_BEATS = NUM_THREADS / WB_LANES,
  localparam int WID_W = clog2_min1(NUM_WARPS),
  localparam int RD_W = $clog2(NUM_REGS),
  localparam int BEAT_W = clog2_min1(NUM_BEATS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WID_W-1:0]            in_wid,
  input  logic [RD_W-1:0]             in_rd,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WID_W-1:0]            out_wid,
  output logic [RD_W-1:0]             out_rd,
  output logic [WB_LANES-1:0]         out_tmask,
  output logic [WB_LANES*XLEN-1:0]    out_data,
  output logic [BEAT_W-1:0]           out_beat,
  output logic                        out_eop,
  output logic [NUM_WARPS-1:0]        warp_busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = WB_LANES * XLEN;
  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [RD_W-1:0] rd;
    logic [NUM_THREADS-1:0] tmask;
    logic [NUM_THREADS*XLEN-1:0] data;
  } entry_t;
  if (NUM_THREADS % WB_LANES != 0) begin : g_bad_lanes
    $error("NUM_THREADS must be a multiple of WB_LANES");
  end
  entry_t wdata, head;
  logic full, empty, push, fire, last, pop;
  logic [BEAT_W-1:0] beat;
  assign wdata = {in_wid, in_rd, in_tmask, in_data};
  assign in_ready = !full;
  // all-zero masks are acknowledged but never stored
  assign push = in_valid && in_ready && |in_tmask;
  assign fire = out_valid && out_ready;
  assign last = beat == BEAT_W'(NUM_BEATS - 1);
  assign pop = fire && last;
  tensor_wb_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(wdata),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset || pop) beat <= '0;
    else if (fire) beat <= beat + 1'b1;
  end
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_busy
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else cnt <= cnt + CW'(push && in_wid == WID_W'(w)) - CW'(pop && head.wid == WID_W'(w));
    end
    assign warp_busy[w] = cnt != '0;
  end
  assign out_valid = !empty;
  always_comb begin
    out_wid = out_valid ? head.wid : '0;
    out_rd = out_valid ? head.rd : '0;
    out_tmask = out_valid ? head.tmask[beat*WB_LANES +: WB_LANES] : '0;
    out_data = out_valid ? head.data[beat*SW +: SW] : '0;
    out_beat = out_valid ? beat : '0;
    out_eop = out_valid && last;
  end
endmodule

// File: tb/tb_tensor_wb_stage.sv
// tb_tensor_wb_stage: directed and randomized checks of tensor_wb_stage against a queue-based model.
module tb_tensor_wb_stage;
  localparam int DP = 2;
  localparam int NB = 2;
  logic clk = 0, reset = 1;
  logic in_valid = 1, in_ready, out_valid, out_ready = 1, out_eop;
  logic [2:0] in_wid = 0, out_wid;
  logic [4:0] in_rd = 0, out_rd;
  logic [3:0] in_tmask = 4'hF;
  logic [127:0] in_data = '0;
  logic [1:0] out_tmask;
  logic [63:0] out_data;
  logic [0:0] out_beat;
  logic [7:0] warp_busy;
  int checks = 0, errors = 0;
  bit started = 0;
  typedef struct {
    logic [2:0] wid;
    logic [4:0] rd;
    logic [3:0] tm;
    logic [127:0] d;
  } ent_t;
  ent_t q[$];
  int busy[8];
  int beat = 0;

  tensor_wb_stage #(.NUM_THREADS(4), .XLEN(32), .NUM_WARPS(8), .NUM_REGS(32), .DEPTH(DP), .WB_LANES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
    .in_rd(in_rd), .in_tmask(in_tmask), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_wid(out_wid), .out_rd(out_rd), .out_tmask(out_tmask),
    .out_data(out_data), .out_beat(out_beat), .out_eop(out_eop), .warp_busy(warp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // model: a queue of whole results plus the beat index into the head result
  always @(posedge clk) begin : model
    int sz;
    bit fire, acc;
    if (reset) begin
      q.delete();
      beat = 0;
      foreach (busy[w]) busy[w] = 0;
    end else begin
      sz = q.size();
      fire = sz != 0 && out_ready;
      acc = in_valid && sz < DP && in_tmask != 0;
      if (fire) begin
        if (beat == NB - 1) begin
          busy[q[0].wid]--;
          void'(q.pop_front());
          beat = 0;
        end else beat++;
      end
      if (acc) begin
        q.push_back('{in_wid, in_rd, in_tmask, in_data});
        busy[in_wid]++;
      end
    end
  end

  always @(negedge clk) if (started) begin : cmp
    logic [127:0] sd;
    logic [3:0] sm;
    logic [7:0] eb;
    for (int w = 0; w < 8; w++) eb[w] = busy[w] != 0;
    check("in_ready", in_ready, q.size() < DP);
    check("warp_busy", warp_busy, eb);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      sd = q[0].d >> (beat * 64);
      sm = q[0].tm >> (beat * 2);
      check("out_wid", out_wid, q[0].wid);
      check("out_rd", out_rd, q[0].rd);
      check("out_tmask", out_tmask, sm[1:0]);
      check("out_data", out_data, sd[63:0]);
      check("out_beat", out_beat, beat[0]);
      check("out_eop", out_eop, beat == NB - 1);
    end else begin
      check("idle_fields", {out_wid, out_rd, out_tmask, out_data, out_beat, out_eop}, '0);
    end
  end

  initial begin
    // reset held two cycles with a valid result presented
    tick;
    started = 1;
    tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_warp_busy", warp_busy, 8'h00);
    check("rst_in_ready", in_ready, 1);
    reset = 0;
    in_valid = 0;
    tick;
    check("post_rst_empty", out_valid, 0);
    // single result split into two beats
    in_valid = 1; in_wid = 3; in_rd = 5; in_tmask = 4'hF;
    in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    tick;
    in_valid = 0;
    check("single_valid", out_valid, 1);
    check("single_wid", out_wid, 3);
    check("single_rd", out_rd, 5);
    check("single_b0_data", out_data, 64'h00000002_00000001);
    check("single_b0_eop", out_eop, 0);
    check("single_busy", warp_busy, 8'h08);
    tick;
    check("single_b1_data", out_data, 64'h00000004_00000003);
    check("single_b1_eop", out_eop, 1);
    tick;
    check("single_done_valid", out_valid, 0);
    check("single_done_busy", warp_busy, 8'h00);
    // partial mask with a stall on the second beat
    in_valid = 1; in_wid = 0; in_rd = 7; in_tmask = 4'b1011;
    in_data = {32'hD0D0_0004, 32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    tick;
    in_valid = 0;
    check("mb_b0_data", out_data, {32'hB0B0_0002, 32'hA0A0_0001});
    check("mb_b0_mask", out_tmask, 2'b11);
    tick;
    out_ready = 0;
    repeat (3) begin
      tick;
      check("mb_b1_data", out_data, {32'hD0D0_0004, 32'hC0C0_0003});
      check("mb_b1_mask", out_tmask, 2'b10);
      check("mb_b1_eop", out_eop, 1);
    end
    out_ready = 1;
    tick;
    check("mb_done", out_valid, 0);
    // backpressure fills the buffer
    out_ready = 0;
    in_valid = 1; in_tmask = 4'hF; in_wid = 1; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick;
    in_wid = 2; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick;
    check("bp_full_ready", in_ready, 0);
    check("bp_busy", warp_busy, 8'h06);
    in_wid = 5;
    tick;
    in_valid = 0;
    check("bp_refused_busy", warp_busy, 8'h06);
    check("bp_head_wid", out_wid, 1);
    out_ready = 1;
    tick;
    check("bp_first_b1", {out_wid, out_beat}, {3'd1, 1'b1});
    check("bp_still_full", in_ready, 0);
    tick;
    check("bp_second_wid", out_wid, 2);
    check("bp_ready_back", in_ready, 1);
    check("bp_busy_after_pop", warp_busy, 8'h04);
    tick;
    tick;
    check("bp_drained", out_valid, 0);
    // zero mask is acknowledged and dropped
    in_valid = 1; in_wid = 4; in_tmask = 4'h0;
    check("zm_ready", in_ready, 1);
    tick;
    in_valid = 0;
    check("zm_no_valid", out_valid, 0);
    check("zm_busy", warp_busy, 8'h00);
    // reset after the first beat is taken
    in_valid = 1; in_wid = 6; in_tmask = 4'b0110; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick;
    in_valid = 0;
    check("mr_b0", out_beat, 0);
    check("mr_busy", warp_busy, 8'h40);
    tick;
    check("mr_b1", out_beat, 1);
    reset = 1;
    tick;
    check("mr_cleared", out_valid, 0);
    check("mr_busy_cleared", warp_busy, 8'h00);
    reset = 0;
    repeat (4) begin
      tick;
      check("mr_no_resume", out_valid, 0);
    end
    // randomized traffic with occasional resets
    repeat (2000) begin
      reset = ($urandom % 150) == 0;
      in_valid = 1'($urandom);
      in_wid = 3'($urandom);
      in_rd = 5'($urandom);
      in_tmask = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom % 10) < 7;
      tick;
    end
    reset = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (8) tick;
    check("final_drained", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
